fir_transposed_serial_mac: RTL and testbench

- Parametrised, time-multiplexed transposed-form FIR filter for the 12 MHz / 300 kHz sample path.
- Uses one multiplier and one adder. These are reused over NUM_TAPS clock cycles per input sample.
- Provides run-time coefficient loading, clear, round-half-up scaling and output saturation.
- Sits after the sample-rate strobe generator and feeds the downstream decimator/DAC interface.

---
 rtl/fir_transposed_serial_mac_if.sv | 41 ++++
 rtl/fir_transposed_serial_mac.sv | 163 ++++++++++++++++
 tb/tb_fir_transposed_serial_mac.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_transposed_serial_mac_if.sv
// Sample/coefficient bus of the serial-MAC transposed FIR.
//   master : drives the sample strobe, sample, clear and coefficient write port;
//            observes the filtered output and status flags.
//   slave  : the filter itself.
// Signals:
//   iEnSample_300k  one-cycle sample strobe
//   iFirIn          signed input sample, valid with the strobe
//   iClr            clear filter state (coefficients kept)
//   iCoeffWe/Addr/Data  coefficient write port
//   oFirOut         signed filtered sample, held between oValid pulses
//   oValid          one-cycle pulse when oFirOut updates
//   oBusy           high while a sample is being processed
//   oOverrun        sticky: strobe arrived while busy
//   oCoeffErr       sticky: coefficient write refused
interface fir_transposed_serial_mac_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned ADDR_W = 6
);
  logic                     iEnSample_300k;
  logic signed [DATA_W-1:0] iFirIn;
  logic                     iClr;
  logic                     iCoeffWe;
  logic [ADDR_W-1:0]        iCoeffAddr;
  logic signed [COEF_W-1:0] iCoeffData;
  logic signed [DATA_W-1:0] oFirOut;
  logic                     oValid;
  logic                     oBusy;
  logic                     oOverrun;
  logic                     oCoeffErr;

  modport master (
    output iEnSample_300k, iFirIn, iClr, iCoeffWe, iCoeffAddr, iCoeffData,
    input  oFirOut, oValid, oBusy, oOverrun, oCoeffErr
  );

  modport slave (
    input  iEnSample_300k, iFirIn, iClr, iCoeffWe, iCoeffAddr, iCoeffData,
    output oFirOut, oValid, oBusy, oOverrun, oCoeffErr
  );
endinterface

// File: rtl/fir_transposed_serial_mac.sv
// Time-multiplexed transposed-form FIR: one multiplier and one adder are reused over
// NUM_TAPS cycles per input sample, followed by one output cycle that rounds half-up,
// shifts right by OUT_SHIFT and saturates to DATA_W bits.
// Ports:
//   iClk_12M  system clock
//   iRsn      synchronous active-low reset
//   fir_io    sample / coefficient bus (slave side), see fir_transposed_serial_mac_if
module fir_transposed_serial_mac #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned NUM_TAPS  = 10,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned OUT_SHIFT = 15,
  parameter int unsigned ADDR_W    = 6
) (
  input logic                        iClk_12M,
  input logic                        iRsn,
  fir_transposed_serial_mac_if.slave fir_io
);

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  localparam int unsigned ProdW = DATA_W + COEF_W;
  // One guard bit so adding the rounding constant can never wrap.
  localparam int unsigned WideW = ACC_W + 1;

  localparam logic [ADDR_W-1:0]       LastIdx = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W:0]         TapsLim = (ADDR_W + 1)'(NUM_TAPS);
  // Half an output LSB; collapses to zero when OUT_SHIFT is zero.
  localparam logic signed [WideW-1:0] RoundC  = (WideW'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [WideW-1:0] SatMax  =
    {{(WideW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [WideW-1:0] SatMin  =
    {{(WideW - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  state_e                   state_q;
  logic [ADDR_W-1:0]        idx_q;
  logic signed [DATA_W-1:0] x_q;
  logic signed [ACC_W-1:0]  y_acc_q;
  // s_q[k] holds transposed state S[k+1].
  logic signed [ACC_W-1:0]  s_q [NUM_TAPS-1];
  logic signed [COEF_W-1:0] h_q [NUM_TAPS];
  logic signed [DATA_W-1:0] fir_out_q;
  logic                     valid_q;
  logic                     busy_q;
  logic                     overrun_q;
  logic                     coeff_err_q;

  logic signed [COEF_W-1:0] h_sel;
  logic signed [ACC_W-1:0]  s_sel;
  logic signed [ProdW-1:0]  prod;
  logic signed [ACC_W-1:0]  mac_sum;
  logic signed [WideW-1:0]  rounded;
  logic signed [WideW-1:0]  shifted;
  logic signed [DATA_W-1:0] out_sat;
  logic                     addr_ok;

  // Tap operand select. The last tap has no upstream state, so s_sel stays zero there.
  always_comb begin
    h_sel = '0;
    s_sel = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (idx_q == ADDR_W'(k)) h_sel = h_q[k];
    end
    for (int k = 0; k < NUM_TAPS - 1; k++) begin
      if (idx_q == ADDR_W'(k)) s_sel = s_q[k];
    end
  end

  assign prod    = x_q * h_sel;
  assign mac_sum = $signed({{(ACC_W - ProdW){prod[ProdW-1]}}, prod}) + s_sel;

  always_comb begin
    rounded = $signed({y_acc_q[ACC_W-1], y_acc_q}) + RoundC;
    shifted = rounded >>> OUT_SHIFT;
    if (shifted > SatMax) begin
      out_sat = SatMax[DATA_W-1:0];
    end else if (shifted < SatMin) begin
      out_sat = SatMin[DATA_W-1:0];
    end else begin
      out_sat = shifted[DATA_W-1:0];
    end
  end

  assign addr_ok = {1'b0, fir_io.iCoeffAddr} < TapsLim;

  always_ff @(posedge iClk_12M) begin
    if (!iRsn) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      x_q         <= '0;
      y_acc_q     <= '0;
      for (int k = 0; k < NUM_TAPS - 1; k++) s_q[k] <= '0;
      for (int k = 0; k < NUM_TAPS; k++) h_q[k] <= '0;
      fir_out_q   <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      coeff_err_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      // Coefficients only change while idle so a sample never mixes two coefficient sets.
      if (fir_io.iCoeffWe) begin
        if (state_q == StIdle && addr_ok) begin
          for (int k = 0; k < NUM_TAPS; k++) begin
            if (fir_io.iCoeffAddr == ADDR_W'(k)) h_q[k] <= fir_io.iCoeffData;
          end
        end else begin
          coeff_err_q <= 1'b1;
        end
      end

      // Clear outranks everything else, including a coincident strobe.
      if (fir_io.iClr) begin
        state_q <= StIdle;
        idx_q   <= '0;
        busy_q  <= 1'b0;
        y_acc_q <= '0;
        for (int k = 0; k < NUM_TAPS - 1; k++) s_q[k] <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (fir_io.iEnSample_300k) begin
              x_q     <= fir_io.iFirIn;
              idx_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= StMac;
            end
          end
          StMac: begin
            if (fir_io.iEnSample_300k) overrun_q <= 1'b1;
            // Ascending taps: S[idx+1] is read before it is overwritten one cycle later.
            if (idx_q == '0) y_acc_q <= mac_sum;
            for (int k = 1; k < NUM_TAPS; k++) begin
              if (idx_q == ADDR_W'(k)) s_q[k-1] <= mac_sum;
            end
            if (idx_q == LastIdx) begin
              state_q <= StOut;
            end else begin
              idx_q <= idx_q + ADDR_W'(1);
            end
          end
          StOut: begin
            if (fir_io.iEnSample_300k) overrun_q <= 1'b1;
            fir_out_q <= out_sat;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign fir_io.oFirOut   = fir_out_q;
  assign fir_io.oValid    = valid_q;
  assign fir_io.oBusy     = busy_q;
  assign fir_io.oOverrun  = overrun_q;
  assign fir_io.oCoeffErr = coeff_err_q;

endmodule

// File: tb/tb_fir_transposed_serial_mac.sv
// Drives four filter configurations from one shared stimulus stream and checks each
// against a sample-level model: y[n] = sum_k x[n-k] * h_{n-k}[k], where h_m is the
// coefficient set in force when sample m was accepted, then round/shift/saturate.
module tb_fir_transposed_serial_mac;

  localparam int NI   = 4;
  localparam int Ring = 64;
  localparam int MaxT = 40;

  function automatic int taps_of(input int g);
    case (g)
      0: return 10;
      1: return 10;
      2: return 2;
      default: return 38;
    endcase
  endfunction

  function automatic int shift_of(input int g);
    return (g == 0) ? 0 : 15;
  endfunction

  typedef struct packed {
    logic signed [15:0] val;
    int                 due;
  } exp_t;

  logic                clk = 1'b0;
  logic                rsn = 1'b0;
  logic                strobe = 1'b0;
  logic signed [15:0]  fir_in = '0;
  logic                clr_s = 1'b0;
  logic                coeff_we = 1'b0;
  logic [5:0]          coeff_addr = '0;
  logic signed [15:0]  coeff_data = '0;

  logic [NI-1:0]       valid;
  logic [NI-1:0]       busy;
  logic [NI-1:0]       ovr;
  logic [NI-1:0]       cerr;
  logic signed [15:0]  fir_out [NI];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fir_transposed_serial_mac_if #(.DATA_W(16), .COEF_W(16), .ADDR_W(6)) ifc ();
    assign ifc.iEnSample_300k = strobe;
    assign ifc.iFirIn         = fir_in;
    assign ifc.iClr           = clr_s;
    assign ifc.iCoeffWe       = coeff_we;
    assign ifc.iCoeffAddr     = coeff_addr;
    assign ifc.iCoeffData     = coeff_data;
    assign valid[g]           = ifc.oValid;
    assign busy[g]            = ifc.oBusy;
    assign ovr[g]             = ifc.oOverrun;
    assign cerr[g]            = ifc.oCoeffErr;
    assign fir_out[g]         = ifc.oFirOut;

    fir_transposed_serial_mac #(
      .DATA_W   (16),
      .COEF_W   (16),
      .NUM_TAPS (taps_of(g)),
      .ACC_W    (40),
      .OUT_SHIFT(shift_of(g)),
      .ADDR_W   (6)
    ) u_dut (
      .iClk_12M(clk),
      .iRsn    (rsn),
      .fir_io  (ifc)
    );
  end

  // Reference model state
  exp_t   exp_q  [NI][$];
  longint h_m    [NI][MaxT];
  longint prod_m [NI][Ring][MaxT];
  int     hcnt_m [NI];
  int     acc_m  [NI];
  bit     act_m  [NI];
  bit     ovr_m  [NI];
  bit     cerr_m [NI];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int g, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d (taps=%0d shift=%0d) got %0d expected %0d at cycle %0d",
               name, g, taps_of(g), shift_of(g), act, exp, cyc);
    end
  endtask

  function automatic logic signed [15:0] scale(input longint y, input int sh);
    longint r;
    r = y + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0));
    r = r >>> sh;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Effect of one input cycle (sampled at edge e) on instance g.
  task automatic model_step(input int g, input int e, input bit stb, input int x,
                            input bit we, input int addr, input int d, input bit clr);
    bit     bsy;
    int     n;
    int     slot;
    longint y;
    n   = taps_of(g);
    bsy = act_m[g] && (e - acc_m[g] <= n + 1);
    if (!bsy) act_m[g] = 1'b0;
    if (we) begin
      if (!bsy && addr < n) h_m[g][addr] = longint'(d);
      else cerr_m[g] = 1'b1;
    end
    if (clr) begin
      hcnt_m[g] = 0;
      if (bsy) begin
        void'(exp_q[g].pop_back());
        act_m[g] = 1'b0;
      end
    end else if (stb) begin
      if (bsy) begin
        ovr_m[g] = 1'b1;
      end else begin
        slot = hcnt_m[g] % Ring;
        for (int k = 0; k < n; k++) prod_m[g][slot][k] = longint'(x) * h_m[g][k];
        hcnt_m[g]++;
        y = 0;
        for (int k = 0; k < n && k < hcnt_m[g]; k++) begin
          y += prod_m[g][(hcnt_m[g] - 1 - k) % Ring][k];
        end
        exp_q[g].push_back('{val: scale(y, shift_of(g)), due: e + n + 1});
        act_m[g] = 1'b1;
        acc_m[g] = e;
      end
    end
  endtask

  task automatic tick(input bit stb, input int x, input bit we, input int addr,
                      input int d, input bit clr);
    int e;
    e          = cyc + 1;
    strobe     = stb;
    fir_in     = 16'(x);
    coeff_we   = we;
    coeff_addr = 6'(addr);
    coeff_data = 16'(d);
    clr_s      = clr;
    for (int g = 0; g < NI; g++) model_step(g, e, stb, x, we, addr, d, clr);
    @(negedge clk);
    strobe   = 1'b0;
    coeff_we = 1'b0;
    clr_s    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic reset_pulse();
    int e;
    e   = cyc + 1;
    rsn = 1'b0;
    for (int g = 0; g < NI; g++) begin
      if (act_m[g] && (e - acc_m[g] <= taps_of(g) + 1)) void'(exp_q[g].pop_back());
      act_m[g]  = 1'b0;
      hcnt_m[g] = 0;
      ovr_m[g]  = 1'b0;
      cerr_m[g] = 1'b0;
      for (int k = 0; k < MaxT; k++) h_m[g][k] = 0;
    end
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("reset_out", g, fir_out[g], 0);
      chk("reset_valid", g, valid[g], 0);
      chk("reset_busy", g, busy[g], 0);
      chk("reset_overrun", g, ovr[g], 0);
      chk("reset_coeff_err", g, cerr[g], 0);
    end
    rsn = 1'b1;
  endtask

  task automatic check_flags();
    for (int g = 0; g < NI; g++) begin
      chk("overrun", g, ovr[g], ovr_m[g]);
      chk("coeff_err", g, cerr[g], cerr_m[g]);
      chk("busy", g, busy[g], (act_m[g] && (cyc - acc_m[g] <= taps_of(g))) ? 1 : 0);
    end
  endtask

  // Scoreboard monitor: every oValid pulse consumes one expected result.
  always @(negedge clk) begin
    exp_t t;
    for (int g = 0; g < NI; g++) begin
      if (valid[g] === 1'b1) begin
        if (exp_q[g].size() == 0) begin
          chk("unexpected_valid", g, 1, 0);
        end else begin
          t = exp_q[g].pop_front();
          chk("out_value", g, fir_out[g], t.val);
          chk("out_latency", g, cyc, t.due);
        end
      end
    end
  end

  initial begin
    int r;
    int gap;
    repeat (2) @(negedge clk);
    reset_pulse();

    // Impulse through h[k] = k+1
    for (int k = 0; k < 38; k++) tick(1'b0, 0, 1'b1, k, k + 1, 1'b0);
    check_flags();
    tick(1'b1, 1, 1'b0, 0, 0, 1'b0);
    idle(39);
    repeat (10) begin
      tick(1'b1, 0, 1'b0, 0, 0, 1'b0);
      idle(39);
    end
    check_flags();

    // Rounding and saturation with all h = 16384
    reset_pulse();
    for (int k = 0; k < 38; k++) tick(1'b0, 0, 1'b1, k, 16384, 1'b0);
    repeat (40) begin
      tick(1'b1, 32767, 1'b0, 0, 0, 1'b0);
      idle(39);
    end
    repeat (40) begin
      tick(1'b1, -32768, 1'b0, 0, 0, 1'b0);
      idle(39);
    end
    tick(1'b0, 0, 1'b0, 0, 0, 1'b1);
    tick(1'b1, 32767, 1'b0, 0, 0, 1'b0);
    idle(39);

    // Overrun: second strobe five cycles after the first
    tick(1'b1, 1234, 1'b0, 0, 0, 1'b0);
    idle(4);
    tick(1'b1, -777, 1'b0, 0, 0, 1'b0);
    check_flags();
    idle(40);
    check_flags();

    // Coefficient guards
    reset_pulse();
    tick(1'b0, 0, 1'b1, 0, 300, 1'b0);
    tick(1'b0, 0, 1'b1, 1, -200, 1'b0);
    tick(1'b0, 0, 1'b1, 10, 77, 1'b0);
    check_flags();
    tick(1'b1, 1000, 1'b0, 0, 0, 1'b0);
    idle(2);
    tick(1'b0, 0, 1'b1, 0, 5000, 1'b0);
    check_flags();
    idle(40);
    tick(1'b1, 2000, 1'b1, 0, -1500, 1'b0);
    idle(39);
    check_flags();

    // Clear with strobe in idle, then clear mid-run
    tick(1'b1, 123, 1'b0, 0, 0, 1'b1);
    check_flags();
    idle(39);
    repeat (3) begin
      tick(1'b1, rnd16(), 1'b0, 0, 0, 1'b0);
      idle(39);
    end
    tick(1'b1, 999, 1'b0, 0, 0, 1'b0);
    idle(2);
    tick(1'b0, 0, 1'b0, 0, 0, 1'b1);
    check_flags();
    idle(40);
    tick(1'b1, 5000, 1'b0, 0, 0, 1'b0);
    idle(39);
    repeat (3) begin
      tick(1'b1, 0, 1'b0, 0, 0, 1'b0);
      idle(39);
    end

    // Reset in the middle of a computation
    tick(1'b1, 4321, 1'b0, 0, 0, 1'b0);
    idle(2);
    reset_pulse();

    // Random regression
    for (int k = 0; k < 40; k++) tick(1'b0, 0, 1'b1, k, rnd16(), 1'b0);
    for (int i = 0; i < 1000; i++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0) tick(1'b0, 0, 1'b1, int'($urandom_range(0, 39)), rnd16(), 1'b0);
      if (r == 1) tick(1'b1, rnd16(), 1'b1, int'($urandom_range(0, 39)), rnd16(), 1'b0);
      else if (r == 2) tick(1'b1, rnd16(), 1'b0, 0, 0, 1'b1);
      else tick(1'b1, rnd16(), 1'b0, 0, 0, 1'b0);
      gap = (r == 3) ? int'($urandom_range(0, 38)) : 39;
      idle(gap);
    end
    idle(50);
    check_flags();

    for (int g = 0; g < NI; g++) chk("pending_outputs", g, exp_q[g].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
